// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory read port, redirect/halt controls and the IF/ID register toward decode.
interface fetch_if;
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned CW   = 32;

  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            id_ready;
  logic            id_valid;
  logic [ILEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            misalign_err;
  logic [CW-1:0]   fetch_count;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc, misalign_err, fetch_count,
    input  imem_data, redirect_valid, redirect_pc, halt, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc, misalign_err, fetch_count,
    output imem_data, redirect_valid, redirect_pc, halt, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-entry IF/ID register with ready/valid
// backpressure, redirect flush, halt and a saturating count of delivered instructions.
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_DELAY = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned CW   = 32;

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be word aligned");
  end
  if (IMEM_DELAY < 1) begin : g_bad_imem_delay
    $error("fetch_unit: IMEM_DELAY must be positive");
  end

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic            mis_q, mis_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic transfer;
  logic slot_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      id_pc_q <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: redirect, then hold on backpressure, then halt, then sequential fetch.
  always_comb begin
    pc_d      = pc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    id_pc_d   = id_pc_q;
    mis_d     = 1'b0;
    cnt_d     = cnt_q;
    transfer  = valid_q && bus.id_ready;
    slot_free = !valid_q || bus.id_ready;

    // A transfer coinciding with a redirect is still a delivered instruction.
    if (transfer && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (bus.redirect_valid) begin
      pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
      valid_d = 1'b0;
      mis_d   = |bus.redirect_pc[1:0];
    end else if (!slot_free) begin
      valid_d = valid_q;
    end else if (bus.halt) begin
      valid_d = 1'b0;
    end else begin
      instr_d = bus.imem_data;
      id_pc_d = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + XLEN'(4);
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.id_valid     = valid_q;
  assign bus.id_instr     = instr_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.misalign_err = mis_q;
  assign bus.fetch_count  = cnt_q;
endmodule
